// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, CORE_OWN, HOST_OWN} arb_state_t;
    typedef enum logic {CORE, HOST} requester_t;

    localparam int AW_D        = 8;
    localparam int DW_D        = 8;
    localparam int MAX_BURST_D = 4;

endpackage

// File: rtl/dmem_arb_if.sv
// Request/grant/memory bundle between the two requesters, the arbiter and the data memory.
interface dmem_arb_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = AW_D,
    parameter int DW = DW_D
) ();

    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_rvalid;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;

    logic [DW-1:0] rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Requesters and memory side
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  core_gnt, core_rvalid, host_gnt, host_rvalid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    // Arbiter side
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output core_gnt, core_rvalid, host_gnt, host_rvalid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating event counter for the arbiter statistics; only built with DMEM_ARB_STATS_EN.
`ifdef DMEM_ARB_STATS_EN
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded bursts for the single-port data memory (core vs host).
// Optional grant/conflict statistics outputs under DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = AW_D,
    parameter int DW        = DW_D,
    parameter int MAX_BURST = MAX_BURST_D
) (
    input  logic        CLK,
    input  logic        RST_N,
    dmem_arb_if.slave   bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0] core_grants,
    output logic [15:0] host_grants,
    output logic [15:0] conflicts
`endif
);

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    arb_state_t    state, state_nx;
    requester_t    last_served;
    logic [3:0]    burst_cnt, burst_nx;
    logic          gnt_c, gnt_h;
    logic          crv, hrv;
    logic          we_sel;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    always_comb begin
        gnt_c    = 1'b0;
        gnt_h    = 1'b0;
        state_nx = state;
        burst_nx = burst_cnt;

        unique case (state)
            IDLE: begin
                if (bus.core_req && (!bus.host_req || last_served == HOST)) gnt_c = 1'b1;
                else if (bus.host_req)                                       gnt_h = 1'b1;
            end
            CORE_OWN: begin
                if (bus.core_req && (burst_cnt < MAXB || !bus.host_req)) gnt_c = 1'b1;
                else if (bus.host_req)                                   gnt_h = 1'b1;
            end
            HOST_OWN: begin
                if (bus.host_req && (burst_cnt < MAXB || !bus.core_req)) gnt_h = 1'b1;
                else if (bus.core_req)                                   gnt_c = 1'b1;
            end
            default: ;
        endcase

        if (!RST_N) begin
            gnt_c = 1'b0;
            gnt_h = 1'b0;
        end

        // Staying with the current owner extends its run; any switch restarts at 1.
        if (gnt_c) begin
            state_nx = CORE_OWN;
            burst_nx = (state != CORE_OWN) ? 4'd1 :
                       (burst_cnt == MAXB) ? MAXB : burst_cnt + 4'd1;
        end else if (gnt_h) begin
            state_nx = HOST_OWN;
            burst_nx = (state != HOST_OWN) ? 4'd1 :
                       (burst_cnt == MAXB) ? MAXB : burst_cnt + 4'd1;
        end else begin
            state_nx = IDLE;
            burst_nx = 4'd0;
        end
    end

    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        if (gnt_c) begin
            we_sel    = bus.core_we;
            addr_sel  = bus.core_addr;
            wdata_sel = bus.core_wdata;
        end else if (gnt_h) begin
            we_sel    = bus.host_we;
            addr_sel  = bus.host_addr;
            wdata_sel = bus.host_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            last_served <= HOST;
            crv         <= 1'b0;
            hrv         <= 1'b0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
            if (gnt_c)      last_served <= CORE;
            else if (gnt_h) last_served <= HOST;
            crv <= gnt_c && !bus.core_we;
            hrv <= gnt_h && !bus.host_we;
        end
    end

    assign bus.core_gnt    = gnt_c;
    assign bus.host_gnt    = gnt_h;
    assign bus.core_rvalid = crv;
    assign bus.host_rvalid = hrv;
    assign bus.rdata       = bus.mem_rdata;
    assign bus.mem_en      = gnt_c | gnt_h;
    assign bus.mem_we      = we_sel;
    assign bus.mem_addr    = addr_sel;
    assign bus.mem_wdata   = wdata_sel;

`ifdef DMEM_ARB_STATS_EN
    sat_counter #(.W(16)) u_core_cnt (
        .clk(CLK), .rst_n(RST_N), .inc(gnt_c), .count(core_grants)
    );
    sat_counter #(.W(16)) u_host_cnt (
        .clk(CLK), .rst_n(RST_N), .inc(gnt_h), .count(host_grants)
    );
    sat_counter #(.W(16)) u_conf_cnt (
        .clk(CLK), .rst_n(RST_N), .inc(bus.core_req & bus.host_req), .count(conflicts)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a streak-based reference model.
module tb_dmem_arbiter;

    localparam int MAXB = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    dmem_arb_if #(.AW(8), .DW(8)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] core_grants, host_grants, conflicts;
`endif

    dmem_arbiter #(.AW(8), .DW(8), .MAX_BURST(MAXB)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .core_grants(core_grants),
        .host_grants(host_grants),
        .conflicts(conflicts)
`endif
    );

    // Environment memory: synchronous read, 1-cycle latency
    logic [7:0] mem [256] = '{default: 8'h00};
    always @(posedge CLK) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    // Reference model state
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    int   streak;
    bit   last_h;
    bit   exp_crv, exp_hrv;
    logic [7:0] exp_rd;
    int   st_c, st_h, st_x;
    bit   gc_seen, gh_seen;
    logic [15:0] hist_c, hist_h, hist_cr, hist_hr;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        streak  = 0;
        last_h  = 1'b1;
        exp_crv = 1'b0;
        exp_hrv = 1'b0;
        st_c = 0; st_h = 0; st_x = 0;
    endtask

    task automatic drive_core(input bit req, input bit we, input logic [7:0] a, input logic [7:0] d);
        bus.core_req = req; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
    endtask

    task automatic drive_host(input bit req, input bit we, input logic [7:0] a, input logic [7:0] d);
        bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    endtask

    // One clock cycle: check DUT against model at negedge, advance model, return at posedge+1.
    task automatic step();
        bit cr, hr, wc, wh, win_h;
        @(negedge CLK);
        cr = bus.core_req;
        hr = bus.host_req;
        if (cr && hr) begin
            // A live run shorter than the limit keeps the port; otherwise the other side gets it.
            win_h = (streak > 0 && streak < MAXB) ? last_h : !last_h;
            wh = win_h;
            wc = !win_h;
        end else begin
            wc = cr;
            wh = hr;
        end

        hist_c  = {hist_c[14:0],  bus.core_gnt};
        hist_h  = {hist_h[14:0],  bus.host_gnt};
        hist_cr = {hist_cr[14:0], bus.core_rvalid};
        hist_hr = {hist_hr[14:0], bus.host_rvalid};

        check_eq("core_gnt", bus.core_gnt, wc);
        check_eq("host_gnt", bus.host_gnt, wh);
        check_eq("mem_en",   bus.mem_en,   wc | wh);
        if (wc) begin
            check_eq("mem_we_c",    bus.mem_we,    bus.core_we);
            check_eq("mem_addr_c",  bus.mem_addr,  bus.core_addr);
            check_eq("mem_wdata_c", bus.mem_wdata, bus.core_wdata);
        end else if (wh) begin
            check_eq("mem_we_h",    bus.mem_we,    bus.host_we);
            check_eq("mem_addr_h",  bus.mem_addr,  bus.host_addr);
            check_eq("mem_wdata_h", bus.mem_wdata, bus.host_wdata);
        end else begin
            check_eq("mem_addr_idle",  bus.mem_addr,  0);
            check_eq("mem_wdata_idle", bus.mem_wdata, 0);
        end
        check_eq("core_rvalid", bus.core_rvalid, exp_crv);
        check_eq("host_rvalid", bus.host_rvalid, exp_hrv);
        if (exp_crv || exp_hrv) check_eq("rdata", bus.rdata, exp_rd);

        exp_crv = wc && !bus.core_we;
        exp_hrv = wh && !bus.host_we;
        if (wc) begin
            if (bus.core_we) ref_mem[bus.core_addr] = bus.core_wdata;
            else             exp_rd = ref_mem[bus.core_addr];
        end else if (wh) begin
            if (bus.host_we) ref_mem[bus.host_addr] = bus.host_wdata;
            else             exp_rd = ref_mem[bus.host_addr];
        end

        if (!wc && !wh) begin
            streak = 0;
        end else begin
            if (wh == last_h && streak > 0) streak = (streak < MAXB) ? streak + 1 : MAXB;
            else                            streak = 1;
            last_h = wh;
        end
        st_c += int'(wc);
        st_h += int'(wh);
        st_x += int'(cr && hr);
        gc_seen = wc;
        gh_seen = wh;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        hist_c = '0; hist_h = '0; hist_cr = '0; hist_hr = '0;
        gc_seen = 1'b0; gh_seen = 1'b0; exp_rd = '0;
        model_reset();
        drive_core(1, 0, 8'h00, 8'h00);
        drive_host(1, 0, 8'h01, 8'h00);

        // Reset held: grants and mem_en gated even with requests pending
        #2;
        check_eq("rst_core_gnt",    bus.core_gnt,    0);
        check_eq("rst_host_gnt",    bus.host_gnt,    0);
        check_eq("rst_mem_en",      bus.mem_en,      0);
        check_eq("rst_core_rvalid", bus.core_rvalid, 0);
        check_eq("rst_host_rvalid", bus.host_rvalid, 0);
        drive_core(0, 0, 0, 0);
        drive_host(0, 0, 0, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        step();

        // Host preload of addr 0..2, then readback of addr 2
        apply_reset();
        for (int unsigned i = 0; i < 3; i++) begin
            drive_host(1, 1, 8'(i), 8'(i));
            step();
        end
        drive_host(1, 0, 8'h02, 8'h00);
        step();
        drive_host(0, 0, 0, 0);
        check_eq("preload_rvalid", bus.host_rvalid, 1);
        check_eq("preload_rdata",  bus.rdata,       8'h02);
        step();
        check_eq("preload_hist_h", hist_h[4:0], 5'b11110);
        check_eq("preload_hist_c", hist_c[4:0], 5'b00000);

        // First conflict after reset: core then host, rvalids in order
        apply_reset();
        drive_core(1, 0, 8'h01, 8'h00);
        drive_host(1, 0, 8'h02, 8'h00);
        step();
        drive_core(0, 0, 0, 0);
        step();
        drive_host(0, 0, 0, 0);
        step();
        check_eq("conflict_hist_c",  hist_c[2:0],  3'b100);
        check_eq("conflict_hist_h",  hist_h[2:0],  3'b010);
        check_eq("conflict_hist_cr", hist_cr[2:0], 3'b010);
        check_eq("conflict_hist_hr", hist_hr[2:0], 3'b001);

        // Burst limit: core continuous, host requests from cycle 1
        apply_reset();
        for (int unsigned cyc = 0; cyc < 10; cyc++) begin
            drive_core(1, 0, 8'(cyc), 8'h00);
            if (cyc == 1) drive_host(1, 1, 8'h10, 8'hA5);
            step();
            if (gh_seen) drive_host(0, 0, 0, 0);
        end
        drive_core(0, 0, 0, 0);
        check_eq("burst_hist_c", hist_c[9:0], 10'b1111011111);
        check_eq("burst_hist_h", hist_h[9:0], 10'b0000100000);
        step();
`ifdef DMEM_ARB_STATS_EN
        check_eq("burst_core_grants", core_grants, 9);
        check_eq("burst_host_grants", host_grants, 1);
        check_eq("burst_conflicts",   conflicts,   4);
`endif

        // Uncontested core run never yields
        apply_reset();
        for (int unsigned cyc = 0; cyc < 8; cyc++) begin
            drive_core(1, 1, 8'(8'h20 + cyc), 8'(cyc * 3));
            step();
        end
        drive_core(0, 0, 0, 0);
        check_eq("uncontested_hist_c", hist_c[7:0], 8'hFF);
        step();

        // Reset mid-read drops the in-flight read and restores core priority
        apply_reset();
        drive_core(1, 0, 8'h05, 8'h00);
        @(negedge CLK);
        check_eq("midrst_gnt_pre", bus.core_gnt, 1);
        RST_N = 1'b0;
        #1;
        check_eq("midrst_gnt_low",    bus.core_gnt, 0);
        check_eq("midrst_mem_en_low", bus.mem_en,   0);
        @(posedge CLK);
        #1;
        check_eq("midrst_rvalid", bus.core_rvalid, 0);
        RST_N = 1'b1;
        model_reset();
        drive_host(1, 0, 8'h06, 8'h00);
        step();
        check_eq("midrst_next_conflict", hist_c[0], 1);
        drive_core(0, 0, 0, 0);
        step();
        drive_host(0, 0, 0, 0);
        step();

        // Randomized traffic, requests held until granted
        apply_reset();
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            if (!bus.core_req || gc_seen) begin
                if ($urandom_range(3) != 0)
                    drive_core(1, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
                else
                    drive_core(0, 0, 0, 0);
            end
            if (!bus.host_req || gh_seen) begin
                if ($urandom_range(3) != 0)
                    drive_host(1, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
                else
                    drive_host(0, 0, 0, 0);
            end
            step();
        end
        drive_core(0, 0, 0, 0);
        drive_host(0, 0, 0, 0);
        step();
        step();
`ifdef DMEM_ARB_STATS_EN
        check_eq("rand_core_grants", core_grants, (st_c > 65535) ? 65535 : st_c);
        check_eq("rand_host_grants", host_grants, (st_h > 65535) ? 65535 : st_h);
        check_eq("rand_conflicts",   conflicts,   (st_x > 65535) ? 65535 : st_x);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port 256x8 data memory (data_mem1 core).
- Requesters: the processor load/store path (core) and the host preload/readback port (host).
- Host uses the port to clear and preload operands (e.g. dividend/divisor at addr 0..2) and to read results after halt.
- Round-robin fairness with a bounded burst allowance; routes 1-cycle read data back to the owning requester.

Parameters:
- AW, 8, memory address width (256 entries).
- DW, 8, data width.
- MAX_BURST, 4, max consecutive grants to one requester while the other is waiting; legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- core_req  input  1  core access request; held until granted.
- core_we  input  1  1 = write, 0 = read.
- core_addr  input  AW  core address.
- core_wdata  input  DW  core write data.
- core_gnt  output  1  combinational grant this cycle.
- core_rvalid  output  1  registered; read data valid for core.
- host_req, host_we, host_addr, host_wdata  input  1/1/AW/DW  same meaning as the core_* inputs, for the host.
- host_gnt  output  1  combinational grant.
- host_rvalid  output  1  registered read valid.
- rdata  output  DW  mem_rdata passed through; qualified by the *_rvalid outputs.
- mem_en, mem_we  output  1  memory command.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid 1 cycle after mem_en with mem_we=0.

Behaviour:
- Reset, async on RST_N low:
  - state=IDLE, burst_cnt=0, last_served=HOST (core wins the first conflict), both rvalid=0.
  - Grants and mem_en are forced 0 while RST_N is low.
- Grant is combinational from req and state. The granted requester's we/addr/wdata drive mem_*, with mem_en=1, in the same cycle. Ungranted requesters must hold their inputs.
- At most one gnt per cycle. No gnt means mem_en=0; mem_addr/mem_wdata are then don't-care and driven 0.
- FSM states: IDLE, CORE_OWN, HOST_OWN.
  - IDLE:
    - Both requesting: grant the requester not equal to last_served.
    - Single requester: grant it.
    - Any grant moves to X_OWN with burst_cnt=1. No request stays in IDLE.
  - X_OWN, where X is the owner and Y the other requester:
    - X_req and (burst_cnt<MAX_BURST or !Y_req): grant X; burst_cnt increments, saturating at MAX_BURST.
    - Otherwise, if Y_req: grant Y, go to Y_OWN, burst_cnt=1.
    - Otherwise: no grant, go to IDLE, burst_cnt=0.
- last_served updates on every grant.
- Read latency is exactly 1. A granted read at cycle t gives X_rvalid=1 at t+1, for one cycle only. Writes produce no rvalid.
- Back-to-back reads from alternating requesters each receive their own rvalid in consecutive cycles.
- Write then read of the same address in consecutive cycles returns the new data; the memory is write-before-read and the arbiter adds no hazard logic.
- Async reset mid-access drops the in-flight read: no rvalid is ever issued for it.
- A request deasserted without a grant is a protocol violation; the result is undefined.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, three outputs are added:
  - core_grants [15:0]: saturating count of core grants.
  - host_grants [15:0]: saturating count of host grants.
  - conflicts [15:0]: saturating count of cycles with both req high.
- The counters clear on RST_N and saturate at 16'hFFFF.
- When undefined, these ports and their logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum logic[1:0] arb_state_t {IDLE, CORE_OWN, HOST_OWN}.
  - typedef enum logic requester_t {CORE, HOST}.
  - Default constants AW_D=8, DW_D=8, MAX_BURST_D=4.
- Sub-module sat_counter (parameter W) is used three times under DMEM_ARB_STATS_EN. No other sub-module.

Test Plan:
- Host preload: host writes 8'h00/8'h01/8'h02 to addr 0/1/2 with core idle. Required: host_gnt=1 each cycle, mem_we=1, core_gnt never asserted. Readback of addr 2 gives host_rvalid one cycle later with rdata=8'h02.
- First conflict after reset: core and host both request reads. Required: core granted first, then host next cycle; core_rvalid at t+1, host_rvalid at t+2.
- Burst limit: core requests continuously for 10 cycles, host requests from cycle 1. Required: core granted 4 times (cycles 0-3), host at cycle 4, then core again, per the FSM rules.
- Uncontested burst: core requests 8 cycles alone. Required: 8 consecutive core grants; burst_cnt saturates at 4 with no yield.
- Reset mid-read: core read granted at t, RST_N pulled low at t+0.5. Required: core_rvalid stays 0, state=IDLE, and the next conflict goes to core.
- Stats (DMEM_ARB_STATS_EN): run the burst-limit scenario. Required: core_grants, host_grants and conflicts match the cycle log.
